lbp_engine: RTL and testbench

//  Initiator side of the gray/LBP memory interface. Reads a 128x128 8-bit gray image over the

---
 rtl/lbp_pkg.sv | 41 ++++
 rtl/lbp_engine_code.sv | 23 ++
 rtl/lbp_engine.sv | 150 +++++++++++++++
 tb/tb_lbp_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared geometry defaults, FSM state encoding and neighbour weights for the LBP engine.
// Option macro: LBP_BORDER_WR_EN (adds the BORDER state for zero-code border writes).
package lbp_pkg;

   localparam int unsigned DEF_IMG_W  = 128;
   localparam int unsigned DEF_IMG_H  = 128;
   localparam int unsigned DEF_ADDR_W = 14;
   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD9,
      SHIFT3,
      WRITE,
      DONE
`ifdef LBP_BORDER_WR_EN
      , BORDER
`endif
   } state_t;

   // Window slots are filled column-major: left column 0..2, centre column 3..5, right 6..8
   localparam logic [3:0] WIN_TL = 4'd0;
   localparam logic [3:0] WIN_L  = 4'd1;
   localparam logic [3:0] WIN_BL = 4'd2;
   localparam logic [3:0] WIN_T  = 4'd3;
   localparam logic [3:0] WIN_C  = 4'd4;
   localparam logic [3:0] WIN_B  = 4'd5;
   localparam logic [3:0] WIN_TR = 4'd6;
   localparam logic [3:0] WIN_R  = 4'd7;
   localparam logic [3:0] WIN_BR = 4'd8;

   localparam logic [7:0] WT_TL = 8'd1;
   localparam logic [7:0] WT_T  = 8'd2;
   localparam logic [7:0] WT_TR = 8'd4;
   localparam logic [7:0] WT_L  = 8'd8;
   localparam logic [7:0] WT_R  = 8'd16;
   localparam logic [7:0] WT_BL = 8'd32;
   localparam logic [7:0] WT_B  = 8'd64;
   localparam logic [7:0] WT_BR = 8'd128;

endpackage

// File: rtl/lbp_engine_code.sv
// Combinational LBP code: each neighbour >= centre (unsigned, ties set) contributes its weight.
module lbp_code
   import lbp_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic [8:0][DATA_W-1:0] win,
   output logic [7:0]             code
);

   always_comb begin
      code = '0;
      if (win[WIN_TL] >= win[WIN_C]) code |= WT_TL;
      if (win[WIN_T]  >= win[WIN_C]) code |= WT_T;
      if (win[WIN_TR] >= win[WIN_C]) code |= WT_TR;
      if (win[WIN_L]  >= win[WIN_C]) code |= WT_L;
      if (win[WIN_R]  >= win[WIN_C]) code |= WT_R;
      if (win[WIN_BL] >= win[WIN_C]) code |= WT_BL;
      if (win[WIN_B]  >= win[WIN_C]) code |= WT_B;
      if (win[WIN_BR] >= win[WIN_C]) code |= WT_BR;
   end

endmodule

// File: rtl/lbp_engine.sv
// LBP engine: 3x3 sliding-window reader over the gray port, one LBP write per pixel, then finish.
// Option macro: LBP_BORDER_WR_EN (also writes border pixels with code 0, no reads for them).
module lbp_engine
   import lbp_pkg::*;
#(
   parameter int unsigned IMG_W  = DEF_IMG_W,
   parameter int unsigned IMG_H  = DEF_IMG_H,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic [DATA_W-1:0] gray_data,
   output logic              lbp_valid,
   output logic [ADDR_W-1:0] lbp_addr,
   output logic [DATA_W-1:0] lbp_data,
   output logic              finish
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = ADDR_W - CW;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 2);
`ifdef LBP_BORDER_WR_EN
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
`endif

   state_t                  state;
   logic [RW-1:0]           row;
   logic [CW-1:0]           col;
   logic [1:0]              ri;
   logic [1:0]              ci;
   logic [8:0][DATA_W-1:0]  win;
   logic [7:0]              code;
   logic [ADDR_W-1:0]       ctr_addr;
   logic [ADDR_W-1:0]       rd_addr;
   logic [3:0]              wr_idx;
   logic                    rd_phase;

   lbp_code #(.DATA_W(DATA_W)) u_code (
      .win  (win),
      .code (code)
   );

   // IMG_W is a power of two, so row*IMG_W+col is a plain concatenation
   assign ctr_addr = {row, col};
   assign rd_addr  = ctr_addr - ADDR_W'(IMG_W + 1) + (ADDR_W'(ri) << CW) + ADDR_W'(ci);
   assign wr_idx   = 4'(ci) * 4'd3 + 4'(ri);
   assign rd_phase = (state == LOAD9) || (state == SHIFT3);

   // gray_req follows gray_ready combinationally so a stall never issues a read
   assign gray_req  = rd_phase & gray_ready;
   assign gray_addr = rd_phase ? rd_addr : '0;
`ifdef LBP_BORDER_WR_EN
   assign lbp_valid = (state == WRITE) || (state == BORDER);
`else
   assign lbp_valid = (state == WRITE);
`endif
   assign lbp_addr  = lbp_valid ? ctr_addr : '0;
   assign lbp_data  = (state == WRITE) ? DATA_W'(code) : '0;
   assign finish    = (state == DONE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         row   <= RW'(1);
         col   <= CW'(1);
         ri    <= '0;
         ci    <= '0;
         win   <= '0;
      end else begin
         case (state)
            IDLE: if (gray_ready) begin
`ifdef LBP_BORDER_WR_EN
               row   <= '0;
               col   <= '0;
               state <= BORDER;
`else
               ri    <= '0;
               ci    <= '0;
               state <= LOAD9;
`endif
            end
            LOAD9, SHIFT3: if (gray_ready) begin
               win[wr_idx] <= gray_data;
               if (ri == 2'd2) begin
                  ri <= '0;
                  if (ci == 2'd2) state <= WRITE;
                  else            ci    <= ci + 2'd1;
               end else begin
                  ri <= ri + 2'd1;
               end
            end
            WRITE: begin
               if (col < COL_LAST) begin
                  // shift window left; SHIFT3 refills only the right column
                  col      <= col + CW'(1);
                  win[5:0] <= win[8:3];
                  ri       <= '0;
                  ci       <= 2'd2;
                  state    <= SHIFT3;
               end else begin
`ifdef LBP_BORDER_WR_EN
                  col   <= COL_MAX;
                  state <= BORDER;
`else
                  if (row < ROW_LAST) begin
                     row   <= row + RW'(1);
                     col   <= CW'(1);
                     ri    <= '0;
                     ci    <= '0;
                     state <= LOAD9;
                  end else begin
                     state <= DONE;
                  end
`endif
               end
            end
`ifdef LBP_BORDER_WR_EN
            BORDER: begin
               if (row == '0 || row == ROW_MAX) begin
                  if (col != COL_MAX)  col <= col + CW'(1);
                  else if (row == '0) begin
                     row <= RW'(1);
                     col <= '0;
                  end else begin
                     state <= DONE;
                  end
               end else if (col == '0) begin
                  col   <= CW'(1);
                  ri    <= '0;
                  ci    <= '0;
                  state <= LOAD9;
               end else begin
                  row <= row + RW'(1);
                  col <= '0;
               end
            end
`endif
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lbp_engine.sv
// Self-checking bench for lbp_engine on a reduced 32x32 image with a golden-model scoreboard.
module tb_lbp_engine;

   localparam int unsigned W    = 32;
   localparam int unsigned H    = 32;
   localparam int unsigned AW   = 10;
   localparam int unsigned DW   = 8;
   localparam int unsigned NPIX = W * H;
`ifdef LBP_BORDER_WR_EN
   localparam int EXP_WR = W * H;
`else
   localparam int EXP_WR = (W - 2) * (H - 2);
`endif
   localparam int RUN_BUDGET = 8000;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          gray_ready = 1'b0;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [DW-1:0] gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [DW-1:0] lbp_data;
   logic          finish;

   logic [DW-1:0] gray_mem [NPIX];
   logic [DW-1:0] lbp_mem  [NPIX];
   wr_t           exp_q [$];
   wr_t           mon_got;
   wr_t           mon_exp;
   int            checks = 0;
   int            failures = 0;
   int            wr_count = 0;
   int            proto_err = 0;

   always #5 clk = ~clk;

   assign gray_data = gray_mem[gray_addr];

   lbp_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .gray_ready (gray_ready),
      .gray_req   (gray_req),
      .gray_addr  (gray_addr),
      .gray_data  (gray_data),
      .lbp_valid  (lbp_valid),
      .lbp_addr   (lbp_addr),
      .lbp_data   (lbp_data),
      .finish     (finish)
   );

   // Write-side memory and scoreboard; captures on negedge like the real memory
   always @(negedge clk) begin
      if (gray_req && !gray_ready) proto_err++;
      if (gray_req && lbp_valid)   proto_err++;
      if (lbp_valid) begin
         lbp_mem[lbp_addr] = lbp_data;
         wr_count++;
         mon_got.addr = lbp_addr;
         mon_got.data = lbp_data;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_write got addr=%0d data=%02h expected no write", lbp_addr, lbp_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               failures++;
               $display("FAIL sb_write got addr=%0d data=%02h expected addr=%0d data=%02h",
                        mon_got.addr, mon_got.data, mon_exp.addr, mon_exp.data);
            end
         end
      end
   end

   function automatic logic [DW-1:0] gp(int r, int c);
      return gray_mem[r * W + c];
   endfunction

   function automatic logic [7:0] ref_code(int r, int c);
      logic [DW-1:0] g;
      g = gp(r, c);
      return {gp(r+1, c+1) >= g, gp(r+1, c) >= g, gp(r+1, c-1) >= g, gp(r, c+1) >= g,
              gp(r, c-1) >= g, gp(r-1, c+1) >= g, gp(r-1, c) >= g, gp(r-1, c-1) >= g};
   endfunction

   task automatic build_golden();
      wr_t e;
      exp_q.delete();
      wr_count = 0;
      for (int i = 0; i < NPIX; i++) lbp_mem[i] = 8'hEE;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            e.addr = AW'(r * W + c);
            if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
               e.data = ref_code(r, c);
               exp_q.push_back(e);
            end else begin
`ifdef LBP_BORDER_WR_EN
               e.data = '0;
               exp_q.push_back(e);
`endif
            end
         end
      end
   endtask

   task automatic start_run();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic run_to_finish(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < RUN_BUDGET; i++) begin
         @(negedge clk);
         if (finish) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      gray_ready = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got req=%b gaddr=%0d valid=%b laddr=%0d data=%02h fin=%b expected all 0",
                  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
      end
   endtask

   task automatic test_protocol();
      int exp_a [13];
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) gray_mem[r * W + c] = DW'(c);
      build_golden();
      exp_a = '{0, W, 2*W, 1, W+1, 2*W+1, 2, W+2, 2*W+2, 0, 3, W+3, 2*W+3};
      start_run();
      @(posedge clk);
`ifndef LBP_BORDER_WR_EN
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         checks++;
         if (i == 9) begin
            if (!(lbp_valid === 1'b1 && gray_req === 1'b0 && lbp_addr === AW'(W + 1))) begin
               failures++;
               $display("FAIL proto_first_write got valid=%b req=%b addr=%0d expected valid=1 req=0 addr=%0d",
                        lbp_valid, gray_req, lbp_addr, W + 1);
            end
         end else if (!(gray_req === 1'b1 && gray_addr === AW'(exp_a[i]))) begin
            failures++;
            $display("FAIL proto_read%0d got req=%b addr=%0d expected req=1 addr=%0d",
                     i, gray_req, gray_addr, exp_a[i]);
         end
      end
`endif
   endtask

   task automatic test_gradient();
      bit to;
      int bad = 0;
      int fin_bad = 0;
      run_to_finish(to);
      checks++;
      if (to !== 1'b0) begin
         failures++;
         $display("FAIL grad_finish_timeout got finish=%b expected 1 within %0d cycles", finish, RUN_BUDGET);
      end
      checks++;
      if (wr_count !== EXP_WR || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL grad_write_count got %0d (left %0d) expected %0d (left 0)", wr_count, exp_q.size(), EXP_WR);
      end
      for (int r = 1; r < H - 1; r++)
         for (int c = 1; c < W - 1; c++)
            if (lbp_mem[r * W + c] !== 8'hD6) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL grad_codes got %0d interior codes differing expected all D6", bad);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (finish !== 1'b1 || gray_req !== 1'b0 || lbp_valid !== 1'b0) fin_bad++;
      end
      checks++;
      if (fin_bad !== 0) begin
         failures++;
         $display("FAIL finish_sticky got %0d bad cycles expected 0", fin_bad);
      end
   endtask

   task automatic test_spot_zero();
      bit to;
      for (int i = 0; i < NPIX; i++) gray_mem[i] = 8'h10;
      gray_mem[5 * W + 5] = 8'h00;
      build_golden();
      start_run();
      run_to_finish(to);
      checks++;
      if (to !== 1'b0 || wr_count !== EXP_WR || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL spot_run got timeout=%b writes=%0d expected timeout=0 writes=%0d", to, wr_count, EXP_WR);
      end
      checks++;
      if (lbp_mem[4 * W + 4] !== 8'h7F) begin
         failures++;
         $display("FAIL spot_4_4 got %02h expected 7f", lbp_mem[4 * W + 4]);
      end
      checks++;
      if (lbp_mem[5 * W + 5] !== 8'hFF) begin
         failures++;
         $display("FAIL spot_5_5 got %02h expected ff", lbp_mem[5 * W + 5]);
      end
      checks++;
      if (lbp_mem[6 * W + 6] !== 8'hFE) begin
         failures++;
         $display("FAIL spot_6_6 got %02h expected fe", lbp_mem[6 * W + 6]);
      end
   endtask

   task automatic test_stall();
      bit to;
      bit found = 1'b0;
      int stall_bad = 0;
      for (int i = 0; i < NPIX; i++) gray_mem[i] = DW'($urandom_range(0, 7));
      build_golden();
      start_run();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (lbp_valid === 1'b1 && lbp_addr === AW'(3 * W + 5)) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL stall_wait got no write at addr %0d expected one within 2000 cycles", 3 * W + 5);
      end
      @(negedge clk);
      checks++;
      if (!(gray_req === 1'b1 && gray_addr === AW'(2 * W + 7))) begin
         failures++;
         $display("FAIL stall_shift_first got req=%b addr=%0d expected req=1 addr=%0d", gray_req, gray_addr, 2 * W + 7);
      end
      @(posedge clk);
      #1 gray_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (gray_req !== 1'b0 || lbp_valid !== 1'b0) stall_bad++;
      end
      checks++;
      if (stall_bad !== 0) begin
         failures++;
         $display("FAIL stall_quiet got %0d active cycles expected 0", stall_bad);
      end
      @(posedge clk);
      #1 gray_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (!(gray_req === 1'b1 && gray_addr === AW'(3 * W + 7))) begin
         failures++;
         $display("FAIL stall_reissue got req=%b addr=%0d expected req=1 addr=%0d", gray_req, gray_addr, 3 * W + 7);
      end
      run_to_finish(to);
      checks++;
      if (to !== 1'b0 || wr_count !== EXP_WR || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL stall_run got timeout=%b writes=%0d expected timeout=0 writes=%0d", to, wr_count, EXP_WR);
      end
   endtask

   task automatic test_reset_midrun();
      bit to;
      for (int i = 0; i < NPIX; i++) gray_mem[i] = DW'($urandom);
      build_golden();
      start_run();
      repeat (1000) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish} !== '0) begin
         failures++;
         $display("FAIL midrun_reset got req=%b gaddr=%0d valid=%b laddr=%0d data=%02h fin=%b expected all 0",
                  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
      end
      @(posedge clk);
      #1;
      build_golden();
      reset = 1'b1;
      @(posedge clk);
`ifndef LBP_BORDER_WR_EN
      @(negedge clk);
      checks++;
      if (!(gray_req === 1'b1 && gray_addr === '0)) begin
         failures++;
         $display("FAIL midrun_restart got req=%b addr=%0d expected req=1 addr=0", gray_req, gray_addr);
      end
`endif
      run_to_finish(to);
      checks++;
      if (to !== 1'b0 || wr_count !== EXP_WR || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL midrun_run got timeout=%b writes=%0d expected timeout=0 writes=%0d", to, wr_count, EXP_WR);
      end
   endtask

   initial begin
      for (int i = 0; i < NPIX; i++) gray_mem[i] = '0;
      test_reset();
      test_protocol();
      test_gradient();
      test_spot_zero();
      test_stall();
      test_reset_midrun();
      checks++;
      if (proto_err !== 0) begin
         failures++;
         $display("FAIL protocol_rules got %0d violations expected 0", proto_err);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
